// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the VGA output path. The board clock is divided
// down to a pixel-rate enable (pix_ce). On each pixel tick the horizontal and
// vertical counters advance. The counters are referenced to the start of sync,
// so hValue == 0 is the first pixel of the hsync pulse and vValue == 0 is the
// first line of the vsync pulse.
//
// Every pixel-related output comes from a register that is loaded on the same
// clkin edge as the counters. Each of these registers is computed from the
// counter values that take effect on that edge. Sync, blank, activeVideo and
// hValue/vValue therefore always describe the same pixel, with no relative
// skew between them.
//
// With the default parameters the block produces 640x480@60 from a 50 MHz
// clkin. Active video spans h 144..783 and v 35..514.
//
// Ports:
//   clkin        in   board clock
//   reset_n      in   asynchronous active-low reset
//   VGA_CLK      out  pixel clock to the DAC (rising edge mid-pixel)
//   VGA_HS       out  horizontal sync, asserted level SYNC_POL
//   VGA_VS       out  vertical sync, asserted level SYNC_POL
//   VGA_BLANK_N  out  low outside the active region
//   VGA_SYNC_N   out  tied low (no sync-on-green)
//   activeVideo  out  high inside the active region
//   hValue       out  horizontal pixel count, 0..H_TOTAL-1
//   vValue       out  vertical line count, 0..V_TOTAL-1
//   pix_ce       out  one clkin-cycle pulse on each pixel advance
//   frame_start  out  one clkin-cycle pulse when the counters reach (0,0)
//------------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   CLK_DIV  = 2,     // clkin cycles per pixel (>= 2)
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter logic SYNC_POL = 1'b0   // asserted sync level, 0 = active-low
) (
    input  logic        clkin,
    input  logic        reset_n,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        activeVideo,
    output logic [15:0] hValue,
    output logic [15:0] vValue,
    output logic        pix_ce,
    output logic        frame_start
);

    //--------------------------------------------------------------------------
    // Derived timing constants
    //--------------------------------------------------------------------------
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam int H_TOTAL_I = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL_I = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [15:0] H_LAST      = 16'(H_TOTAL_I - 1);
    localparam logic [15:0] V_LAST      = 16'(V_TOTAL_I - 1);
    localparam logic [15:0] H_SYNC_END  = 16'(H_SYNC);
    localparam logic [15:0] V_SYNC_END  = 16'(V_SYNC);
    localparam logic [15:0] H_ACT_START = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_ACT_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] V_ACT_START = 16'(V_SYNC + V_BP);
    localparam logic [15:0] V_ACT_END   = 16'(V_SYNC + V_BP + V_ACTIVE);

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [15:0]      h_q;
    logic [15:0]      v_q;

    // Values the registers take on the coming edge
    logic [DIV_W-1:0] div_next;
    logic [15:0]      h_next;
    logic [15:0]      v_next;
    logic             tick;
    logic             hs_next;
    logic             vs_next;
    logic             active_next;
    logic             origin_next;

    //--------------------------------------------------------------------------
    // Divider and raster counters (next-state)
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch. Otherwise a
        // path that leaves it unassigned would infer a latch.
        div_next = div_q + 1'b1;
        h_next   = h_q;
        v_next   = v_q;
        tick     = (div_q == DIV_LAST);

        if (tick) begin
            div_next = '0;
            if (h_q == H_LAST) begin
                h_next = '0;
                if (v_q == V_LAST) begin
                    v_next = '0;
                end else begin
                    v_next = v_q + 16'd1;
                end
            end else begin
                h_next = h_q + 16'd1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Decode from the next counter values. The registered outputs then line up
    // with the registered counters.
    //--------------------------------------------------------------------------
    always_comb begin
        hs_next     = (h_next < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vs_next     = (v_next < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        active_next = (h_next >= H_ACT_START) && (h_next < H_ACT_END) &&
                      (v_next >= V_ACT_START) && (v_next < V_ACT_END);
        origin_next = (h_next == 16'd0) && (v_next == 16'd0);
    end

    //--------------------------------------------------------------------------
    // Registers
    //
    // The counters reset to the last pixel of the frame, so the first pixel
    // tick after release lands on (0,0) and raises frame_start.
    // VGA_CLK is computed from the divider value being loaded. Its rising edge
    // falls halfway through the pixel, and its falling edge coincides with the
    // counter update.
    //--------------------------------------------------------------------------
    always_ff @(posedge clkin or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then sample their inputs from before the edge, regardless
        // of statement order.
        if (!reset_n) begin
            div_q       <= '0;
            h_q         <= H_LAST;
            v_q         <= V_LAST;
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
            activeVideo <= 1'b0;
            VGA_BLANK_N <= 1'b0;
            VGA_CLK     <= 1'b0;
            pix_ce      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_next;
            h_q         <= h_next;
            v_q         <= v_next;
            VGA_HS      <= hs_next;
            VGA_VS      <= vs_next;
            activeVideo <= active_next;
            VGA_BLANK_N <= active_next;
            VGA_CLK     <= (div_next >= DIV_HALF);
            pix_ce      <= tick;
            frame_start <= tick && origin_next;
        end
    end

    assign hValue     = h_q;
    assign vValue     = v_q;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
//------------------------------------------------------------------------------
// tb_vga_timing_gen
//
// This bench runs three instances side by side:
//   D : default parameters (640x480, CLK_DIV=2, active-low sync)
//   A : small raster 17x10, CLK_DIV=2, active-low sync
//   B : the same small raster with CLK_DIV=4 and active-high sync
//
// The reference model works directly from the number of clkin edges since
// reset release. From that count it derives the pixel tick count, and from
// the tick count it derives a linear raster position. h and v are that
// position's remainder and quotient by H_TOTAL. Every output is then decoded
// from h, v and the parameter rules.
//
// Literal expectations pin the model at the first tick, at the sync and active
// boundaries, at the line wrap, and after a mid-line reset.
//------------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic        vga_clk;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        sync_n;
        logic        active;
        logic [15:0] h;
        logic [15:0] v;
        logic        pix_ce;
        logic        frame_start;
    } obs_t;

    typedef struct {
        int   cd;
        int   hs, hbp, ha, hfp;
        int   vs, vbp, va, vfp;
        logic pol;
    } cfg_t;

    logic clkin   = 1'b0;
    logic reset_n = 1'b0;
    int   n;           // clkin edges since reset release
    int   tests = 0;
    int   fails = 0;

    obs_t obs [3];
    cfg_t cfg [3];
    int   last_fs [3];
    int   act_cnt [3];

    always #5 clkin = ~clkin;

    always @(posedge clkin or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    //--------------------------------------------------------------------------
    // DUTs
    //--------------------------------------------------------------------------
    logic        d_clk, d_hs, d_vs, d_bn, d_sn, d_av, d_pce, d_fs;
    logic [15:0] d_h, d_v;
    logic        a_clk, a_hs, a_vs, a_bn, a_sn, a_av, a_pce, a_fs;
    logic [15:0] a_h, a_v;
    logic        b_clk, b_hs, b_vs, b_bn, b_sn, b_av, b_pce, b_fs;
    logic [15:0] b_h, b_v;

    vga_timing_gen dut_d (
        .clkin(clkin), .reset_n(reset_n), .VGA_CLK(d_clk), .VGA_HS(d_hs),
        .VGA_VS(d_vs), .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn),
        .activeVideo(d_av), .hValue(d_h), .vValue(d_v), .pix_ce(d_pce),
        .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1), .SYNC_POL(1'b0)
    ) dut_a (
        .clkin(clkin), .reset_n(reset_n), .VGA_CLK(a_clk), .VGA_HS(a_hs),
        .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn),
        .activeVideo(a_av), .hValue(a_h), .vValue(a_v), .pix_ce(a_pce),
        .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clkin(clkin), .reset_n(reset_n), .VGA_CLK(b_clk), .VGA_HS(b_hs),
        .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn),
        .activeVideo(b_av), .hValue(b_h), .vValue(b_v), .pix_ce(b_pce),
        .frame_start(b_fs)
    );

    assign obs[0] = '{d_clk, d_hs, d_vs, d_bn, d_sn, d_av, d_h, d_v, d_pce, d_fs};
    assign obs[1] = '{a_clk, a_hs, a_vs, a_bn, a_sn, a_av, a_h, a_v, a_pce, a_fs};
    assign obs[2] = '{b_clk, b_hs, b_vs, b_bn, b_sn, b_av, b_h, b_v, b_pce, b_fs};

    //--------------------------------------------------------------------------
    // Reference model: outputs after k clkin edges since reset release
    //--------------------------------------------------------------------------
    function automatic obs_t model(input cfg_t c, input int k);
        obs_t o;
        int ht, vt, frame, t, pos, h, v;
        ht    = c.hs + c.hbp + c.ha + c.hfp;
        vt    = c.vs + c.vbp + c.va + c.vfp;
        frame = ht * vt;
        t     = k / c.cd;                              // pixel ticks so far
        pos   = (t == 0) ? frame - 1 : (t - 1) % frame; // reset sits on last pixel
        h     = pos % ht;
        v     = pos / ht;
        o.h           = 16'(h);
        o.v           = 16'(v);
        o.hs          = (h < c.hs) ? c.pol : ~c.pol;
        o.vs          = (v < c.vs) ? c.pol : ~c.pol;
        o.active      = (h >= c.hs + c.hbp) && (h < c.hs + c.hbp + c.ha) &&
                        (v >= c.vs + c.vbp) && (v < c.vs + c.vbp + c.va);
        o.blank_n     = o.active;
        o.sync_n      = 1'b0;
        o.vga_clk     = ((k % c.cd) >= (c.cd / 2));
        o.pix_ce      = (k > 0) && ((k % c.cd) == 0);
        o.frame_start = o.pix_ce && (pos == 0);
        return o;
    endfunction

    function automatic string inst_name(input int i);
        return (i == 0) ? "D" : (i == 1) ? "A" : "B";
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic wait_n(input int target);
        int guard = 0;
        while (n != target && guard < 20000) begin
            @(negedge clkin);
            guard++;
        end
        if (n != target) check("wait_budget", 64'(n), 64'(target));
    endtask

    //--------------------------------------------------------------------------
    // Per-cycle compare plus frame-period and active-pixel accounting
    //--------------------------------------------------------------------------
    always @(negedge clkin) begin
        obs_t e;
        int   ht, vt;
        for (int i = 0; i < 3; i++) begin
            e = model(cfg[i], n);
            check({"cycle_", inst_name(i)}, 64'(obs[i]), 64'(e));
            if (!reset_n) begin
                last_fs[i] = -1;
                act_cnt[i] = 0;
            end else begin
                if (obs[i].pix_ce && obs[i].active) act_cnt[i]++;
                if (obs[i].frame_start) begin
                    ht = cfg[i].hs + cfg[i].hbp + cfg[i].ha + cfg[i].hfp;
                    vt = cfg[i].vs + cfg[i].vbp + cfg[i].va + cfg[i].vfp;
                    if (last_fs[i] >= 0) begin
                        check({"frame_period_", inst_name(i)},
                              64'(n - last_fs[i]), 64'(ht * vt * cfg[i].cd));
                        check({"active_ticks_", inst_name(i)},
                              64'(act_cnt[i]), 64'(cfg[i].ha * cfg[i].va));
                    end
                    last_fs[i] = n;
                    act_cnt[i] = 0;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    //--------------------------------------------------------------------------
    initial begin
        cfg[0] = '{cd: 2, hs: 96, hbp: 48, ha: 640, hfp: 16,
                   vs: 2, vbp: 33, va: 480, vfp: 10, pol: 1'b0};
        cfg[1] = '{cd: 2, hs: 4, hbp: 3, ha: 8, hfp: 2,
                   vs: 2, vbp: 2, va: 5, vfp: 1, pol: 1'b0};
        cfg[2] = '{cd: 4, hs: 4, hbp: 3, ha: 8, hfp: 2,
                   vs: 2, vbp: 2, va: 5, vfp: 1, pol: 1'b1};
        for (int i = 0; i < 3; i++) begin
            last_fs[i] = -1;
            act_cnt[i] = 0;
        end

        repeat (3) @(negedge clkin);
        // Reset state, D: (799,524), syncs idle high, blanked
        check("D_reset", 64'({d_h, d_v, d_hs, d_vs, d_av, d_bn, d_clk, d_pce, d_fs, d_sn}),
              64'({16'd799, 16'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("B_reset_sync", 64'({b_hs, b_vs, b_h, b_v}),
              64'({1'b0, 1'b0, 16'd16, 16'd9}));
        #1 reset_n = 1'b1;

        wait_n(1);
        check("D_n1", 64'({d_pce, d_fs, d_clk, d_h}), 64'({1'b0, 1'b0, 1'b1, 16'd799}));
        check("B_n1_clk", 64'(b_clk), 64'(1'b0));
        wait_n(2);
        check("D_first_tick", 64'({d_h, d_v, d_hs, d_vs, d_fs, d_pce, d_clk}),
              64'({16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));
        check("B_n2_clk", 64'({b_clk, b_pce}), 64'({1'b1, 1'b0}));
        wait_n(3);
        check("D_fs_one_cycle", 64'({d_fs, d_pce, d_h}), 64'({1'b0, 1'b0, 16'd0}));
        check("B_n3_clk", 64'(b_clk), 64'(1'b1));
        wait_n(4);
        check("B_first_tick", 64'({b_h, b_v, b_hs, b_vs, b_fs, b_pce, b_clk}),
              64'({16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}));
        wait_n(150);
        check("A_before_active", 64'({a_h, a_v, a_av, a_bn}),
              64'({16'd6, 16'd4, 1'b0, 1'b0}));
        wait_n(152);
        check("A_first_active", 64'({a_h, a_v, a_av, a_bn}),
              64'({16'd7, 16'd4, 1'b1, 1'b1}));
        wait_n(192);
        check("D_hs_last_low", 64'({d_h, d_hs}), 64'({16'd95, 1'b0}));
        wait_n(194);
        check("D_hs_release", 64'({d_h, d_hs}), 64'({16'd96, 1'b1}));
        wait_n(290);
        check("D_h144_v0_blank", 64'({d_h, d_v, d_av}), 64'({16'd144, 16'd0, 1'b0}));
        wait_n(302);
        check("A_last_active", 64'({a_h, a_v, a_av}), 64'({16'd14, 16'd8, 1'b1}));
        wait_n(304);
        check("A_after_active", 64'({a_h, a_v, a_av}), 64'({16'd15, 16'd8, 1'b0}));
        wait_n(342);
        check("A_second_frame", 64'({a_fs, a_h, a_v}), 64'({1'b1, 16'd0, 16'd0}));
        wait_n(1600);
        check("D_line_end", 64'({d_h, d_v}), 64'({16'd799, 16'd0}));
        wait_n(1602);
        check("D_line_wrap", 64'({d_h, d_v, d_vs}), 64'({16'd0, 16'd1, 1'b0}));
        wait_n(3000);

        // Mid-line asynchronous reset, between clock edges
        @(posedge clkin);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check({"async_reset_", inst_name(i)}, 64'(obs[i]), 64'(model(cfg[i], 0)));
        check("D_async_reset_lit", 64'({d_h, d_v, d_hs, d_av, d_clk}),
              64'({16'd799, 16'd524, 1'b1, 1'b0, 1'b0}));
        repeat (2) @(negedge clkin);
        #1 reset_n = 1'b1;

        wait_n(2);
        check("D_restart_tick", 64'({d_fs, d_h, d_v}), 64'({1'b1, 16'd0, 16'd0}));
        wait_n(4);
        check("B_restart_tick", 64'({b_fs, b_h, b_v}), 64'({1'b1, 16'd0, 16'd0}));
        wait_n(1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA output path: divides the board clock into a pixel-rate enable and runs horizontal/vertical counters.
- Drives VGA sync/blank/clock pins and the activeVideo/hValue/vValue bus consumed directly by the downstream pattern generator.
- Counters are sync-origin referenced: hValue 0 is the first hsync pixel.
- Defaults give 640x480@60 from 50 MHz (active h 144..783, v 35..514).

Parameters:
CLK_DIV, 2, clkin cycles per pixel (>=2)
H_SYNC, 96, hsync width in pixels
H_BP, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
SYNC_POL, 0, asserted level of VGA_HS/VGA_VS (0 = active-low)

Ports:
clkin  input  1  board clock (50 MHz)
reset_n  input  1  reset
VGA_CLK  output  1  pixel clock to DAC
VGA_HS  output  1  horizontal sync
VGA_VS  output  1  vertical sync
VGA_BLANK_N  output  1  low outside active region
VGA_SYNC_N  output  1  tied 0 (no sync-on-green)
activeVideo  output  1  high inside active region
hValue  output  16  horizontal pixel count
vValue  output  16  vertical line count
pix_ce  output  1  one clkin-cycle pulse per pixel advance
frame_start  output  1  one clkin-cycle pulse when counters reach (0,0)

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clkin. Reset is the only way to clear the block.
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800).
- V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (525).
- Reset values:
  - div counter 0.
  - hValue = H_TOTAL-1; vValue = V_TOTAL-1.
  - VGA_HS = VGA_VS = ~SYNC_POL.
  - activeVideo = 0, VGA_BLANK_N = 0.
  - VGA_CLK = 0, pix_ce = 0, frame_start = 0, VGA_SYNC_N = 0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_ce registered high for exactly one clkin cycle when div==CLK_DIV-1.
  - VGA_CLK registered high while div >= CLK_DIV/2 (integer division). Its rising edge lands mid-pixel, never on a counter update.
- Counter update, on each clkin edge where the pix_ce condition is met:
  - hValue increments.
  - At H_TOTAL-1, hValue wraps to 0 and vValue increments.
  - At V_TOTAL-1 with hValue wrap, vValue wraps to 0.
  - Counters hold between pixel ticks.
- Decode is registered on the same edge as the counters, computed from the next counter values, so sync/active/counter outputs always describe the same pixel (zero relative skew).
  - VGA_HS = SYNC_POL while hValue < H_SYNC, else ~SYNC_POL.
  - VGA_VS = SYNC_POL while vValue < V_SYNC, else ~SYNC_POL.
  - activeVideo = 1 iff H_SYNC+H_BP <= hValue < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vValue < V_SYNC+V_BP+V_ACTIVE.
  - VGA_BLANK_N = activeVideo.
- frame_start: registered pulse on the clkin cycle where counters become (0,0). First occurrence is the first pixel tick after reset release (clkin cycle CLK_DIV).
- Counter widths: 16 bits. Upper bits stay 0 for any legal parameter set.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). After release, timing restarts exactly as from power-up; no partial-frame state is kept.

Test Plan:
- Reset release, defaults -> first pix_ce at clkin cycle 2; hValue=0, vValue=0, VGA_HS=0, VGA_VS=0, frame_start=1 for one cycle.
- Run one line -> VGA_HS low for hValue 0..95 (192 clkin cycles); hValue 799 -> 0 with vValue incremented by 1.
- Scan frame -> first activeVideo=1 at (144,35), last at (783,514); 640*480 = 307200 active pixel ticks per frame; VGA_BLANK_N equals activeVideo on every cycle.
- Frame period -> consecutive frame_start pulses exactly 800*525*2 = 840000 clkin cycles apart; VGA_VS low for vValue 0..1 (3200 clkin cycles).
- Assert reset_n mid-line at (400,200) -> outputs at reset values within the same cycle; after release, frame_start again at clkin cycle 2.
- CLK_DIV=4, SYNC_POL=1 -> pix_ce every 4 cycles; VGA_CLK high 2 of 4 cycles; HS/VS active-high; counter sequence otherwise identical.
